// File: rtl/ram_pkg.sv
// Shared encodings for the RAM port arbiter: access types, rw polarity,
// FSM states, port indices and small helpers for access size and read-data extension.
package ram_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    function automatic logic [2:0] type_size(input logic [1:0] t);
        logic [2:0] s;
        case (t)
            TYPE_BYTE: s = 3'd1;
            TYPE_HALF: s = 3'd2;
            default:   s = 3'd4;
        endcase
        return s;
    endfunction

    // The RAM returns data right-justified; bits above the access width are not meaningful.
    function automatic logic [31:0] extend_rdata(input logic [1:0] t, input logic [31:0] d);
        logic [31:0] r;
        case (t)
            TYPE_BYTE: r = {24'b0, d[7:0]};
            TYPE_HALF: r = {16'b0, d[15:0]};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin grant between fetch and data ports; the priority
// register favours the port that was not served by the last completed access.
module ram_rr_arbiter
    import ram_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant
);

    logic prio_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_reg <= PORT_IF;
        end else if (update) begin
            prio_reg <= ~served;
        end
    end

    always_comb begin
        grant_valid = if_req | d_req;
        if (if_req && d_req) begin
            grant = prio_reg;
        end else if (d_req) begin
            grant = PORT_D;
        end else begin
            grant = PORT_IF;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the 256x8 RAM between instruction fetch and data ports with range checks and a MOC timeout.
// Optional macro RAM_ARB_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        ram_rw,
    output logic        ram_mov,
    output logic [1:0]  ram_type,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_moc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_reg;
    logic               port_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               grant_valid;
    logic               grant;
    logic [1:0]         sel_type;
    logic [31:0]        sel_addr;
    logic               sel_rw;
    logic [31:0]        sel_din;
    logic [32:0]        sel_end;
    logic               sel_bad;

    ram_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .d_req       (d_req),
        .update      (state_reg == ST_RESP),
        .served      (port_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Fields of the winning requester and the checks that decide the short error path.
    always_comb begin
        sel_type = (grant == PORT_D) ? d_type  : TYPE_WORD;
        sel_addr = (grant == PORT_D) ? d_addr  : if_addr;
        sel_rw   = (grant == PORT_D) ? d_rw    : RW_READ;
        sel_din  = (grant == PORT_D) ? d_wdata : 32'd0;
        sel_end  = {1'b0, sel_addr} + 33'(type_size(sel_type)) - 33'd1;
        sel_bad  = (sel_type == TYPE_ILL) || (sel_end > 33'(MEM_BYTES - 1));
`ifdef RAM_ARB_ALIGN_CHECK_EN
        if ((sel_type == TYPE_HALF) && sel_addr[0]) begin
            sel_bad = 1'b1;
        end
        if ((sel_type == TYPE_WORD) && (sel_addr[1:0] != 2'b00)) begin
            sel_bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            port_reg  <= PORT_IF;
            cnt_reg   <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            ram_rw    <= 1'b0;
            ram_mov   <= 1'b0;
            ram_type  <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        port_reg <= grant;
                        if (sel_bad) begin
                            state_reg <= ST_RESP;
                            if (grant == PORT_D) begin
                                d_ack <= 1'b1;
                                d_err <= 1'b1;
                            end else begin
                                if_ack <= 1'b1;
                                if_err <= 1'b1;
                            end
                        end else begin
                            ram_rw    <= sel_rw;
                            ram_type  <= sel_type;
                            ram_addr  <= sel_addr;
                            ram_din   <= sel_din;
                            state_reg <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    ram_mov   <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ST_STROBE;
                end
                ST_STROBE: begin
                    // MOC wins over an expiring count in the same cycle.
                    if (ram_moc) begin
                        ram_mov   <= 1'b0;
                        state_reg <= ST_RESP;
                        if (port_reg == PORT_D) begin
                            d_ack <= 1'b1;
                            if (ram_rw == RW_READ) begin
                                d_rdata <= extend_rdata(ram_type, ram_dout);
                            end
                        end else begin
                            if_ack <= 1'b1;
                            if (ram_rw == RW_READ) begin
                                if_rdata <= ram_dout;
                            end
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        ram_mov   <= 1'b0;
                        state_reg <= ST_RESP;
                        if (port_reg == PORT_D) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                            if_err <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: big-endian RAM device, transaction-level reference model,
// per-cycle compare, directed literal checks and a randomized two-port phase.
module tb_ram_port_arbiter;

    localparam int MEM_BYTES = 256;
    localparam int TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_rw;
    logic [1:0]  d_type;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ack, if_err, d_ack, d_err;
    logic        ram_rw, ram_mov, ram_moc;
    logic [1:0]  ram_type;
    logic [31:0] ram_addr, ram_din, ram_dout;

    always #5 clk = ~clk;

    ram_port_arbiter #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .ram_rw(ram_rw), .ram_mov(ram_mov), .ram_type(ram_type), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_moc(ram_moc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] model_mem [MEM_BYTES];
    logic [7:0] dev_mem   [MEM_BYTES];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a, input logic [1:0] t);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes(t); i++) v = {v[23:0], model_mem[8'(a + 32'(i))]};
        return v;
    endfunction

    function automatic void mdl_wr(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
        int n = nbytes(t);
        for (int i = 0; i < n; i++) model_mem[8'(a + 32'(i))] = 8'(d >> (8 * (n - 1 - i)));
    endfunction

    // RAM device: asserts MOC after moc_delay strobe cycles, garbage above the access width.
    int  moc_delay = 1;
    int  strobe_cnt = 0;
    bit  wrote = 0;
    always @(negedge clk) begin
        if (reset) begin
            ram_moc = 1'b0; strobe_cnt = 0; wrote = 0;
        end else if (ram_mov) begin
            strobe_cnt++;
            if (strobe_cnt >= moc_delay) begin
                logic [31:0] v, g;
                int n;
                n = nbytes(ram_type);
                v = 32'd0;
                for (int i = 0; i < n; i++) v = {v[23:0], dev_mem[8'(ram_addr + 32'(i))]};
                g = $urandom;
                ram_dout = (n == 1) ? {g[31:8], v[7:0]} : (n == 2) ? {g[31:16], v[15:0]} : v;
                if (!ram_rw && !wrote) begin
                    for (int i = 0; i < n; i++) dev_mem[8'(ram_addr + 32'(i))] = 8'(ram_din >> (8 * (n - 1 - i)));
                    wrote = 1;
                end
                ram_moc = 1'b1;
            end
        end else begin
            ram_moc = 1'b0; strobe_cnt = 0; wrote = 0;
        end
    end

    // Transaction-level model: which port is served, when its ack appears, and with what result.
    int          force_delay = 1;
    int          free_cyc = 0;
    bit          prio = 0;
    bit          ev_valid = 0, ev_port, ev_short, ev_err, ev_rw;
    int          ev_g, ev_cyc;
    logic [1:0]  ev_type;
    logic [31:0] ev_addr, ev_din, ev_rdata;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            ev_valid = 0; free_cyc = cyc + 1; prio = 0;
        end else if (cyc >= free_cyc && (if_req || d_req)) begin
            bit bad;
            int dly;
            ev_port = (if_req && d_req) ? prio : d_req;
            ev_type = ev_port ? d_type : 2'd2;
            ev_addr = ev_port ? d_addr : if_addr;
            ev_rw   = ev_port ? d_rw : 1'b1;
            ev_din  = ev_port ? d_wdata : 32'd0;
            bad = (ev_type == 2'd3) || (longint'(ev_addr) + nbytes(ev_type) - 1 > MEM_BYTES - 1);
`ifdef RAM_ARB_ALIGN_CHECK_EN
            if (ev_type == 2'd1 && ev_addr[0]) bad = 1;
            if (ev_type == 2'd2 && ev_addr[1:0] != 2'd0) bad = 1;
`endif
            ev_valid = 1; ev_g = cyc;
            if (bad) begin
                ev_short = 1; ev_err = 1; ev_cyc = cyc;
            end else begin
                ev_short = 0;
                if (force_delay != 0) dly = force_delay;
                else if ($urandom_range(0, 9) == 0) dly = TIMEOUT + 2;
                else if ($urandom_range(0, 4) == 0) dly = TIMEOUT;
                else dly = $urandom_range(1, 4);
                moc_delay = dly;
                if (dly <= TIMEOUT) begin
                    ev_cyc = cyc + 1 + dly; ev_err = 0;
                    if (ev_rw) ev_rdata = mdl_rd(ev_addr, ev_type);
                    else mdl_wr(ev_addr, ev_type, ev_din);
                end else begin
                    ev_cyc = cyc + 1 + TIMEOUT; ev_err = 1;
                end
            end
            free_cyc = ev_cyc + 2;
            prio = !ev_port;
        end
    end

    // Per-cycle compare, sampled 1 time unit after the rising edge.
    logic [31:0] exp_if_rdata = 0, exp_d_rdata = 0;
    int  ack_log [$];
    bit  mov_seen = 0;
    always @(posedge clk) begin
        bit e_if, e_d, e_mov;
        #1;
        e_if  = ev_valid && cyc == ev_cyc && !ev_port;
        e_d   = ev_valid && cyc == ev_cyc && ev_port;
        e_mov = ev_valid && !ev_short && cyc > ev_g && cyc < ev_cyc;
        if (reset) begin
            exp_if_rdata = 0; exp_d_rdata = 0;
        end else if ((e_if || e_d) && !ev_err && ev_rw) begin
            if (e_if) exp_if_rdata = ev_rdata;
            else exp_d_rdata = ev_rdata;
        end
        chk("if_ack", if_ack, e_if);
        chk("d_ack", d_ack, e_d);
        if (e_if) chk("if_err", if_err, ev_err);
        if (e_d) chk("d_err", d_err, ev_err);
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("ram_mov", ram_mov, e_mov);
        if (e_mov) begin
            chk("ram_addr", ram_addr, ev_addr);
            chk("ram_rw", ram_rw, ev_rw);
            chk("ram_type", ram_type, ev_type);
            if (!ev_rw) chk("ram_din", ram_din, ev_din);
        end
        if (ram_mov) mov_seen = 1;
        if (if_ack) begin
            ack_log.push_back(0);
            $display("txn cycle=%0d port=fetch err=%0d rdata=%h", cyc, if_err, if_rdata);
        end
        if (d_ack) begin
            ack_log.push_back(1);
            $display("txn cycle=%0d port=data err=%0d rdata=%h", cyc, d_err, d_rdata);
        end
    end

    task automatic txn(input bit port, input logic rw, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic err, output logic [31:0] rd);
        int  start;
        bit  got = 0;
        @(negedge clk);
        if (port) begin d_rw = rw; d_type = t; d_addr = a; d_wdata = wd; d_req = 1; end
        else begin if_addr = a; if_req = 1; end
        start = cyc + 1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(posedge clk); #2;
            got = port ? d_ack : if_ack;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_ack_wait: no ack within 400 cycles, an ack was required", port ? "d" : "if");
        end
        lat = cyc - start;
        err = port ? d_err : if_err;
        rd  = port ? d_rdata : if_rdata;
        @(negedge clk);
        if (port) d_req = 0; else if_req = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, completion was required");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, fc, dc;
        logic err;
        logic [31:0] rd;
        reset = 1; if_req = 0; d_req = 0; d_rw = 1; d_type = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        ram_moc = 0; ram_dout = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            model_mem[i] = v; dev_mem[i] = v;
        end
        repeat (2) @(negedge clk);
        chk("rst_if_ack", if_ack, 0);   chk("rst_d_ack", d_ack, 0);
        chk("rst_ram_mov", ram_mov, 0); chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_type", ram_type, 0); chk("rst_ram_rw", ram_rw, 0);
        chk("rst_d_rdata", d_rdata, 0); chk("rst_if_rdata", if_rdata, 0);
        reset = 0;

        force_delay = 1;
        txn(1, 0, 2'd2, 32'h10, 32'hDEADBEEF, lat, err, rd);
        chk("wr_lat", lat, 2); chk("wr_err", err, 0);
        txn(1, 1, 2'd2, 32'h10, 0, lat, err, rd);
        chk("rd_word", rd, 32'hDEADBEEF); chk("rd_lat", lat, 2); chk("rd_err", err, 0);
        txn(1, 1, 2'd0, 32'h11, 0, lat, err, rd);
        chk("rd_byte", rd, 32'h000000AD);
        txn(1, 1, 2'd1, 32'h12, 0, lat, err, rd);
        chk("rd_half", rd, 32'h0000BEEF);
        txn(0, 1, 2'd2, 32'h10, 0, lat, err, rd);
        chk("if_word", rd, 32'hDEADBEEF); chk("if_lat", lat, 2);

        force_delay = 100;
        txn(1, 1, 2'd2, 32'h10, 0, lat, err, rd);
        chk("to_lat", lat, 1 + TIMEOUT); chk("to_err", err, 1); chk("to_rdata", rd, 32'h0000BEEF);
        chk("to_mov_low", ram_mov, 0);
        force_delay = TIMEOUT;
        txn(1, 1, 2'd0, 32'h13, 0, lat, err, rd);
        chk("moc_at_limit_lat", lat, 1 + TIMEOUT); chk("moc_at_limit_err", err, 0);
        chk("moc_at_limit_rd", rd, 32'h000000EF);

        force_delay = 1;
        mov_seen = 0;
        txn(1, 1, 2'd2, 32'hFE, 0, lat, err, rd);
        chk("range_lat", lat, 0); chk("range_err", err, 1);
        txn(1, 1, 2'd3, 32'h20, 0, lat, err, rd);
        chk("type_lat", lat, 0); chk("type_err", err, 1);
        txn(1, 1, 2'd0, 32'h100, 0, lat, err, rd);
        chk("byte_range_err", err, 1);
        chk("err_no_mov", mov_seen, 0);
        txn(1, 1, 2'd0, 32'hFF, 0, lat, err, rd);
        chk("last_byte_err", err, 0);

        txn(1, 0, 2'd2, 32'h02, 32'h01234567, lat, err, rd);
        txn(1, 1, 2'd2, 32'h02, 0, lat, err, rd);
`ifdef RAM_ARB_ALIGN_CHECK_EN
        chk("align_lat", lat, 0); chk("align_err", err, 1);
`else
        chk("misalign_lat", lat, 2); chk("misalign_err", err, 0); chk("misalign_rd", rd, 32'h01234567);
`endif

        apply_reset();
        ack_log.delete();
        @(negedge clk);
        if_addr = 32'h40; d_rw = 1; d_type = 2'd2; d_addr = 32'h20; if_req = 1; d_req = 1;
        fc = 0; dc = 0;
        for (int n = 0; n < 200 && (fc < 3 || dc < 3); n++) begin
            @(posedge clk); #2;
            if (if_ack) fc++;
            if (d_ack) dc++;
            @(negedge clk);
            if (fc >= 3) if_req = 0;
            if (dc >= 3) d_req = 0;
        end
        if_req = 0; d_req = 0;
        chk("rr_count", ack_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), (i < ack_log.size()) ? ack_log[i] : -1, i % 2);

        force_delay = 100;
        @(negedge clk);
        if_addr = 32'h10; if_req = 1;
        repeat (4) @(negedge clk);
        chk("pre_reset_mov", ram_mov, 1);
        fc = ack_log.size();
        reset = 1; #1;
        chk("async_mov", ram_mov, 0); chk("async_addr", ram_addr, 0);
        chk("async_if_rdata", if_rdata, 0); chk("async_d_rdata", d_rdata, 0);
        force_delay = 1;
        repeat (2) @(negedge clk);
        chk("no_ack_in_reset", ack_log.size(), fc);
        reset = 0;
        dc = 0;
        for (int n = 0; n < 50 && dc == 0; n++) begin
            @(posedge clk); #2;
            if (if_ack) dc = n + 1;
        end
        chk("post_reset_lat", dc, 3);
        chk("post_reset_rd", if_rdata, 32'hDEADBEEF);
        @(negedge clk); if_req = 0;

        force_delay = 0;
        fork
            begin
                int l; logic e; logic [31:0] r;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    txn(0, 1, 2'd2, ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300)) : {24'd0, 6'($urandom), 2'b00}, 0, l, e, r);
                end
            end
            begin
                int l; logic e; logic [31:0] r;
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    txn(1, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                        32'($urandom_range(0, 259)), $urandom, l, e, r);
                end
            end
        join
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
